nbit_rr_stream_mux: RTL and testbench
=====================================

Name: nbit_rr_stream_mux

Overview:
- Parametrised, registered successor to the n-bit 4-to-1 multiplexer: selects one of CH n-bit input channels and forwards it to a single output.
- Each input channel and the output use a valid/ready handshake.
- Two selection modes: fixed select (S drives the choice, as in the combinational mux) and round-robin arbitration.
- Output is held in a one-entry register. Sits between multiple producers and one shared consumer/datapath.

Parameters:
- n, 4, data width of each channel and of Y.
- CH, 4, number of input channels (must be >= 2).
- SW, $clog2(CH), width of S and Y_CH (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- IN  input  CH*n  flattened channel data; channel k occupies IN[k*n +: n].
- IN_VALID  input  CH  per-channel valid.
- IN_READY  output  CH  per-channel ready (one-hot or zero).
- MODE  input  1  0 = fixed select via S, 1 = round-robin.
- S  input  SW  channel select, used when MODE=0.
- Y  output  n  registered output data.
- Y_VALID  output  1  output register holds valid data.
- Y_READY  input  1  consumer accepts Y this cycle.
- Y_CH  output  SW  index of the channel that produced Y.

Behaviour:
- Reset, asynchronous on rst_n low: Y=0, Y_VALID=0, Y_CH=0, round-robin pointer ptr=0, IN_READY=0 while in reset.
  - Reset mid-operation discards any held word; no partial transfer is reported.
- Output state:
  - EMPTY (Y_VALID=0) and FULL (Y_VALID=1).
  - load_en = !Y_VALID || Y_READY, so the block accepts a new word in the same cycle the held word drains.
- Grant, combinational, computed only when load_en=1; otherwise IN_READY=0.
  - MODE=0: grant channel S if IN_VALID[S]=1. If S >= CH (non-power-of-two CH), no grant.
  - MODE=1: search channels ptr, ptr+1, ..., wrapping modulo CH; the first channel with IN_VALID=1 wins.
- IN_READY = one-hot grant. A transfer on channel k occurs when IN_VALID[k] && IN_READY[k].
- On a transfer at a clock edge:
  - Y <= channel k data, Y_CH <= k, Y_VALID <= 1.
  - If MODE=1, ptr <= (k+1) mod CH. In MODE=0, ptr is unchanged.
- If there is no transfer but Y_READY=1 while FULL: Y_VALID <= 0. Y and Y_CH keep their last value.
- Latency: 1 cycle from input handshake to Y_VALID.
- Throughput: 1 word per cycle when Y_READY is held high.
- Stall: while Y_VALID=1 and Y_READY=0, Y, Y_CH and Y_VALID are stable and IN_READY=0.
- MODE or S changes take effect at the next grant evaluation. ptr is not reset on a mode change.
- Producers must hold data stable while valid and not ready. The block never drops or duplicates a word.

Decomposition:
- Shared package: MODE_FIXED=1'b0, MODE_RR=1'b1; output state encoding ST_EMPTY/ST_FULL.
- One sub-module: rr_arbiter (params CH; inputs req[CH], ptr[SW], en; output one-hot gnt).
  - Keeps the wrap-around priority search isolated and separately testable.
- The top level contains the fixed/RR grant mux, the data selection and the output register.

Test Plan:
- Fixed mode, 4-bit stimulus:
  - Setup: CH=4, n=4, MODE=0, channel data A=0011, B=0110, C=1100, D=1001, all IN_VALID=1, Y_READY=1.
  - Stimulus: S stepped 00, 01, 10, 11.
  - Required: Y=0011, 0110, 1100, 1001 each one cycle after the select; Y_CH = S.
- Round-robin fairness:
  - Stimulus: MODE=1, all valid, Y_READY=1 for 8 cycles.
  - Required: Y_CH sequence 0,1,2,3,0,1,2,3 with IN_READY rotating one-hot.
- Round-robin with sparse requests:
  - Stimulus: IN_VALID=1010, ptr=0.
  - Required: grant ch1 then ch3, then wrap to ch1; ch0 and ch2 are never granted.
- Backpressure:
  - Stimulus: Y_VALID=1, Y_READY=0 for 3 cycles.
  - Required: Y and Y_CH stable, IN_READY=0000. On Y_READY=1, a new word loads the same cycle.
- Async reset mid-stream:
  - Stimulus: rst_n low between clock edges while FULL.
  - Required: immediately Y=0, Y_VALID=0, Y_CH=0. After release, RR restarts at ch0.
- Invalid select:
  - Setup: CH=3, MODE=0.
  - Stimulus: S=11 with all valid.
  - Required: IN_READY=000, Y_VALID drains to 0 and stays 0.

Source files
------------

// File: rtl/nbit_rr_stream_mux_pkg.sv
// Shared definitions for the registered round-robin stream multiplexer.
package nbit_rr_stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Channel index reached by stepping 'off' positions from 'base', wrapping at 'ch'.
    function automatic int rr_index(input int base, input int off, input int ch);
        return (base + off) % ch;
    endfunction

endpackage

// File: rtl/nbit_rr_stream_mux_rr_arbiter.sv
// Wrap-around priority arbiter: the first requester at or after ptr wins.
module rr_arbiter
    import nbit_rr_stream_mux_pkg::*;
#(
    parameter int CH = 4,
    parameter int SW = $clog2(CH)
) (
    input  logic [CH-1:0] req,
    input  logic [SW-1:0] ptr,
    input  logic          en,
    output logic [CH-1:0] gnt
);

    logic [SW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        if (en) begin
            for (int i = 0; i < CH; i++) begin
                idx = SW'(rr_index(int'(ptr), i, CH));
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/nbit_rr_stream_mux.sv
// CH-input valid/ready multiplexer with fixed or round-robin selection and a
// one-entry output register that can refill in the same cycle it drains.
module nbit_rr_stream_mux
    import nbit_rr_stream_mux_pkg::*;
#(
    parameter int n  = 4,
    parameter int CH = 4,
    parameter int SW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH*n-1:0] IN,
    input  logic [CH-1:0]   IN_VALID,
    output logic [CH-1:0]   IN_READY,
    input  logic            MODE,
    input  logic [SW-1:0]   S,
    output logic [n-1:0]    Y,
    output logic            Y_VALID,
    input  logic            Y_READY,
    output logic [SW-1:0]   Y_CH
);

    out_state_e    state_q, state_d;
    logic [n-1:0]  y_q, y_d;
    logic [SW-1:0] y_ch_q, y_ch_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          load_en;
    logic [CH-1:0] rr_gnt;
    logic [CH-1:0] fix_gnt;
    logic [CH-1:0] gnt;
    logic          xfer;
    logic [SW-1:0] gnt_idx;
    logic [n-1:0]  sel_data;

    assign load_en = (state_q == ST_EMPTY) || Y_READY;

    rr_arbiter #(
        .CH (CH),
        .SW (SW)
    ) u_rr_arbiter (
        .req (IN_VALID),
        .ptr (ptr_q),
        .en  (load_en),
        .gnt (rr_gnt)
    );

    // S values beyond the last channel (non-power-of-two CH) never grant.
    always_comb begin
        fix_gnt = '0;
        if (load_en && (int'(S) < CH)) begin
            if (IN_VALID[S]) begin
                fix_gnt[S] = 1'b1;
            end
        end
    end

    assign gnt      = (MODE == MODE_RR) ? rr_gnt : fix_gnt;
    assign IN_READY = rst_n ? gnt : '0;
    assign xfer     = |gnt;

    always_comb begin
        gnt_idx  = '0;
        sel_data = '0;
        for (int k = 0; k < CH; k++) begin
            if (gnt[k]) begin
                gnt_idx  = SW'(k);
                sel_data = IN[k*n +: n];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            y_q     <= '0;
            y_ch_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            y_ch_q  <= y_ch_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        y_ch_d  = y_ch_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            state_d = ST_FULL;
            y_d     = sel_data;
            y_ch_d  = gnt_idx;
            if (MODE == MODE_RR) begin
                ptr_d = SW'(rr_index(int'(gnt_idx), 1, CH));
            end
        end else if ((state_q == ST_FULL) && Y_READY) begin
            state_d = ST_EMPTY;
        end
    end

    // Output logic
    always_comb begin
        Y_VALID = (state_q == ST_FULL);
        Y       = y_q;
        Y_CH    = y_ch_q;
    end

endmodule

// File: tb/tb_nbit_rr_stream_mux.sv
// Self-checking bench: fixed-select vector table, directed round-robin,
// backpressure, reset and invalid-select sequences, then random traffic.
module tb_nbit_rr_stream_mux;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [15:0] in4;
    logic [3:0]  iv4, ir4;
    logic        mode4;
    logic [1:0]  s4;
    logic [3:0]  y4;
    logic        yv4, yr4;
    logic [1:0]  ych4;

    logic [11:0] in3;
    logic [2:0]  iv3, ir3;
    logic        mode3;
    logic [1:0]  s3;
    logic [3:0]  y3;
    logic        yv3, yr3;
    logic [1:0]  ych3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nbit_rr_stream_mux #(.n(4), .CH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .IN(in4), .IN_VALID(iv4), .IN_READY(ir4),
        .MODE(mode4), .S(s4), .Y(y4), .Y_VALID(yv4), .Y_READY(yr4), .Y_CH(ych4)
    );

    nbit_rr_stream_mux #(.n(4), .CH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .IN(in3), .IN_VALID(iv3), .IN_READY(ir3),
        .MODE(mode3), .S(s3), .Y(y3), .Y_VALID(yv3), .Y_READY(yr3), .Y_CH(ych3)
    );

    typedef struct {
        logic [1:0] s;
        logic [3:0] v;
        logic [3:0] ir;
        logic [3:0] y;
        logic [1:0] ch;
        logic       yv;
    } vec_t;

    vec_t       tbl[7];
    logic [3:0] dat[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state for the random phase
    logic       pend[4];
    logic [3:0] pdat[4];
    logic       m_valid;
    logic [3:0] m_y;
    int         m_ch, m_ptr, g, c, ex;

    initial begin
        dat[0] = 4'h3; dat[1] = 4'h6; dat[2] = 4'hC; dat[3] = 4'h9;
        tbl[0] = '{2'd0, 4'hF,    4'b0001, 4'h3, 2'd0, 1'b1};
        tbl[1] = '{2'd1, 4'hF,    4'b0010, 4'h6, 2'd1, 1'b1};
        tbl[2] = '{2'd2, 4'hF,    4'b0100, 4'hC, 2'd2, 1'b1};
        tbl[3] = '{2'd3, 4'hF,    4'b1000, 4'h9, 2'd3, 1'b1};
        tbl[4] = '{2'd1, 4'b0101, 4'b0000, 4'h9, 2'd3, 1'b0};
        tbl[5] = '{2'd2, 4'b0101, 4'b0100, 4'hC, 2'd2, 1'b1};
        tbl[6] = '{2'd0, 4'b0000, 4'b0000, 4'hC, 2'd2, 1'b0};

        rst_n = 1'b0;
        in4 = {4'h9, 4'hC, 4'h6, 4'h3};
        iv4 = 4'hF; mode4 = 1'b0; s4 = 2'd0; yr4 = 1'b1;
        in3 = {4'hC, 4'h6, 4'h3};
        iv3 = 3'b000; mode3 = 1'b0; s3 = 2'd0; yr3 = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_y", 32'(y4), 32'h0);
        chk("reset_yvalid", 32'(yv4), 32'h0);
        chk("reset_ych", 32'(ych4), 32'h0);
        chk("reset_in_ready", 32'(ir4), 32'h0);
        iv4 = 4'h0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Fixed-select table
        for (int i = 0; i < 7; i++) begin
            s4 = tbl[i].s; iv4 = tbl[i].v;
            #1;
            chk($sformatf("fix%0d_in_ready", i), 32'(ir4), 32'(tbl[i].ir));
            @(posedge clk); #1;
            chk($sformatf("fix%0d_y", i), 32'(y4), 32'(tbl[i].y));
            chk($sformatf("fix%0d_ych", i), 32'(ych4), 32'(tbl[i].ch));
            chk($sformatf("fix%0d_yvalid", i), 32'(yv4), 32'(tbl[i].yv));
        end

        // Round-robin fairness, pointer still at 0
        mode4 = 1'b1; iv4 = 4'hF;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("rr%0d_in_ready", i), 32'(ir4), 32'(1 << (i % 4)));
            @(posedge clk); #1;
            chk($sformatf("rr%0d_ych", i), 32'(ych4), 32'(i % 4));
            chk($sformatf("rr%0d_y", i), 32'(y4), 32'(dat[i % 4]));
        end

        // Sparse requests: only ch1 and ch3
        iv4 = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("sparse%0d_ych", i), 32'(ych4), (i % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Backpressure: held word ch3, ptr back at 0
        yr4 = 1'b0; iv4 = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d_in_ready", i), 32'(ir4), 32'h0);
            @(posedge clk); #1;
            chk($sformatf("stall%0d_y", i), 32'(y4), 32'h9);
            chk($sformatf("stall%0d_ych", i), 32'(ych4), 32'd3);
            chk($sformatf("stall%0d_yvalid", i), 32'(yv4), 32'd1);
        end
        yr4 = 1'b1;
        #1;
        chk("unstall_in_ready", 32'(ir4), 32'b0001);
        @(posedge clk); #1;
        chk("unstall_ych", 32'(ych4), 32'd0);
        chk("unstall_y", 32'(y4), 32'h3);
        chk("unstall_yvalid", 32'(yv4), 32'd1);

        // Async reset mid-cycle while FULL with ptr=1
        #1 rst_n = 1'b0;
        #1;
        chk("areset_y", 32'(y4), 32'h0);
        chk("areset_yvalid", 32'(yv4), 32'h0);
        chk("areset_ych", 32'(ych4), 32'h0);
        chk("areset_in_ready", 32'(ir4), 32'h0);
        #2 rst_n = 1'b1;
        #1;
        chk("post_reset_in_ready", 32'(ir4), 32'b0001);
        @(posedge clk); #1;
        chk("post_reset_ych", 32'(ych4), 32'd0);
        chk("post_reset_yvalid", 32'(yv4), 32'd1);

        // Invalid select on the three-channel instance
        iv3 = 3'b111; s3 = 2'd0;
        #1;
        chk("ch3_sel0_in_ready", 32'(ir3), 32'b001);
        @(posedge clk); #1;
        chk("ch3_sel0_yvalid", 32'(yv3), 32'd1);
        chk("ch3_sel0_y", 32'(y3), 32'h3);
        s3 = 2'd3;
        #1;
        chk("ch3_bad_in_ready", 32'(ir3), 32'b000);
        @(posedge clk); #1;
        chk("ch3_bad_drain", 32'(yv3), 32'd0);
        chk("ch3_bad_in_ready2", 32'(ir3), 32'b000);
        @(posedge clk); #1;
        chk("ch3_bad_stay", 32'(yv3), 32'd0);

        // Random traffic against a transaction-level model
        iv4 = 4'h0; mode4 = 1'b1;
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        m_valid = 1'b0; m_y = 4'h0; m_ch = 0; m_ptr = 0;
        for (int k = 0; k < 4; k++) begin
            pend[k] = 1'b0; pdat[k] = 4'h0;
        end
        for (int t = 0; t < 400; t++) begin
            for (int k = 0; k < 4; k++) begin
                if (!pend[k] && $urandom_range(0, 2) == 0) begin
                    pend[k] = 1'b1;
                    pdat[k] = 4'($urandom_range(0, 15));
                end
                iv4[k] = pend[k];
                in4[k*4 +: 4] = pdat[k];
            end
            if ($urandom_range(0, 15) == 0) mode4 = ~mode4;
            s4  = 2'($urandom_range(0, 3));
            yr4 = ($urandom_range(0, 3) != 0);
            #1;
            g = -1;
            if (!m_valid || yr4) begin
                if (!mode4) begin
                    if (pend[s4]) g = int'(s4);
                end else begin
                    for (int j = 0; j < 4; j++) begin
                        c = (m_ptr + j) % 4;
                        if (g < 0 && pend[c]) g = c;
                    end
                end
            end
            ex = (g >= 0) ? (1 << g) : 0;
            chk("rand_in_ready", 32'(ir4), 32'(ex));
            @(posedge clk);
            if (g >= 0) begin
                m_valid = 1'b1; m_y = pdat[g]; m_ch = g; pend[g] = 1'b0;
                if (mode4) m_ptr = (g + 1) % 4;
            end else if (yr4) begin
                m_valid = 1'b0;
            end
            #1;
            chk("rand_yvalid", 32'(yv4), 32'(m_valid));
            chk("rand_y", 32'(y4), 32'(m_y));
            chk("rand_ych", 32'(ych4), 32'(m_ch));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
